opmux_arbiter: RTL and testbench

OPMUX_ARBITER -- requirements
Module: opmux_arbiter

---
 rtl/opmux_arbiter.sv | 114 +++++++++++
 tb/tb_opmux_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/opmux_arbiter.sv
// Round-robin 16-way arbiter that captures one requester's data word and
// holds it until accepted downstream. Optional grant lock: OPMUX_ARB_LOCK_EN.
module opmux_arbiter #(
  parameter int CHANSIZE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              req,
  input  logic [16*CHANSIZE-1:0]   chan_data,
  output logic [15:0]              sel,
  output logic                     out_valid,
  output logic [CHANSIZE-1:0]      out_data,
  input  logic                     out_ready,
  output logic [15:0]              ack
`ifdef OPMUX_ARB_LOCK_EN
  ,
  input  logic                     lock
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              r_state;
  logic [3:0]          r_ptr;
  logic [3:0]          r_gnt_idx;
  logic [15:0]         r_sel;
  logic                r_out_valid;
  logic [CHANSIZE-1:0] r_out_data;

  logic                w_found;
  logic [3:0]          w_idx;
  logic                w_xfer;
  logic                w_lock_held;
  logic                w_lock;

`ifdef OPMUX_ARB_LOCK_EN
  logic r_lock_held;
  assign w_lock_held = r_lock_held;
  assign w_lock      = lock;
`else
  assign w_lock_held = 1'b0;
  assign w_lock      = 1'b0;
`endif

  // A locked grant only ever re-offers the previous winner; otherwise scan
  // ptr, ptr+1, ... with 4-bit wraparound.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_found = 1'b0;
    w_idx   = '0;
    if (w_lock_held) begin
      w_found = req[r_gnt_idx];
      w_idx   = r_gnt_idx;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (!w_found && req[4'(r_ptr + 4'(k))]) begin
          w_found = 1'b1;
          w_idx   = 4'(r_ptr + 4'(k));
        end
      end
    end
  end

  assign w_xfer = r_out_valid & out_ready;

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      r_sel       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef OPMUX_ARB_LOCK_EN
      r_lock_held <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sel       <= 16'h0001 << w_idx;
            r_out_data  <= chan_data[w_idx*CHANSIZE +: CHANSIZE];
            r_gnt_idx   <= w_idx;
            r_out_valid <= 1'b1;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          // Grant index survives the return to IDLE so a lock can reuse it.
          if (w_xfer) begin
            r_sel       <= '0;
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
            if (!w_lock) r_ptr <= r_gnt_idx + 4'd1;
`ifdef OPMUX_ARB_LOCK_EN
            r_lock_held <= w_lock;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign ack       = r_sel & {16{w_xfer}};

endmodule

// File: tb/tb_opmux_arbiter.sv
// Self-checking bench for opmux_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_opmux_arbiter;

  localparam int CHANSIZE = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [15:0]            req;
  logic [16*CHANSIZE-1:0] chan_data;
  logic [15:0]            sel;
  logic                   out_valid;
  logic [CHANSIZE-1:0]    out_data;
  logic                   out_ready;
  logic [15:0]            ack;
  logic                   lock;

  int n_checks = 0;
  int n_errors = 0;

  opmux_arbiter #(.CHANSIZE(CHANSIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .chan_data (chan_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .ack       (ack)
`ifdef OPMUX_ARB_LOCK_EN
    ,
    .lock      (lock)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference model: one pending word (or none), a round-robin start point,
  // and the lock bookkeeping.
  bit          m_busy;
  int          m_ptr;
  int          m_g;
  int          m_data;
  bit          m_lock_held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int slice_of(input int i);
    return int'(chan_data[i*CHANSIZE +: CHANSIZE]);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_g = 0; m_data = 0; m_lock_held = 0;
  endtask

  task automatic model_edge();
    bit lk;
`ifdef OPMUX_ARB_LOCK_EN
    lk = lock;
`else
    lk = 0;
`endif
    if (m_busy) begin
      if (out_ready) begin
        m_busy = 0;
        if (lk) m_lock_held = 1;
        else begin
          m_lock_held = 0;
          m_ptr = (m_g + 1) % 16;
        end
      end
    end else if (m_lock_held) begin
      if (req[m_g]) begin
        m_busy = 1; m_data = slice_of(m_g);
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (req[(m_ptr + k) % 16]) begin
          m_g = (m_ptr + k) % 16;
          m_busy = 1;
          m_data = slice_of(m_g);
          break;
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_sel();
    return m_busy ? (16'h0001 << m_g) : 16'h0000;
  endfunction

  // One clock: check the combinational ack against the current inputs, then
  // advance the edge and check the registered outputs.
  task automatic step();
    #1;
    check("ack", ack, (m_busy && out_ready) ? exp_sel() : 16'h0000);
    @(posedge clk);
    model_edge();
    #1;
    check("sel", sel, exp_sel());
    check("out_valid", out_valid, m_busy);
    if (m_busy) check("out_data", out_data, m_data);
    check("onehot", $onehot0(sel), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 16'hFFFF; chan_data = '1; out_ready = 1'b1; lock = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    // Outputs pinned at reset values despite active requests.
    check("rst_sel", sel, 16'h0000);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ack", ack, 16'h0000);
    rst_n = 1'b1;
    req = 16'h0000;

    // Single requester 0 with data A.
    req = 16'h0001; chan_data = '0; chan_data[3:0] = 4'hA; out_ready = 1'b1;
    step();
    check("t30_sel", sel, 16'h0001);
    check("t30_data", out_data, 4'hA);
    check("t30_ack", ack, 16'h0001);
    req = 16'h0000;
    step();
    check("t30_idle", sel, 16'h0000);
    req = 16'hFFFF;
    step();
    check("t30_ptr1", sel, 16'h0002);

    // All requesting: strict round-robin from 0 after reset.
    do_reset();
    req = 16'hFFFF; out_ready = 1'b1;
    for (int i = 0; i < 34; i++) begin
      for (int j = 0; j < 16; j++) chan_data[j*CHANSIZE +: CHANSIZE] = CHANSIZE'($urandom);
      step();
      if (i % 2 == 0) check("t31_order", sel, 16'h0001 << ((i / 2) % 16));
      else            check("t31_gap", sel, 16'h0000);
    end

    // Wrap from 15 to 0.
    do_reset();
    req = 16'h4000;
    step(); step();
    req = 16'h8001;
    step();
    check("t32_g15", sel, 16'h8000);
    step();
    step();
    check("t32_g0", sel, 16'h0001);
    step();

    // Backpressure holds grant 3, then release moves on to 4.
    do_reset();
    req = 16'h0018; out_ready = 1'b0;
    step();
    check("t33_g3", sel, 16'h0008);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t33_hold", sel, 16'h0008);
      check("t33_noack", ack, 16'h0000);
    end
    out_ready = 1'b1;
    #1;
    check("t33_ack", ack, 16'h0008);
    step();
    step();
    check("t33_g4", sel, 16'h0010);
    step();

    // Asynchronous reset while busy on requester 7.
    do_reset();
    req = 16'h0080; out_ready = 1'b0;
    step();
    check("t34_g7", sel, 16'h0080);
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t34_sel", sel, 16'h0000);
    check("t34_valid", out_valid, 0);
    check("t34_ack", ack, 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    check("t34_held", sel, 16'h0000);
    rst_n = 1'b1;
    req = 16'h0082;
    step();
    check("t34_g1", sel, 16'h0002);
    step();

`ifdef OPMUX_ARB_LOCK_EN
    do_reset();
    req = 16'h0004; out_ready = 1'b0;
    step(); step();
    req = 16'h0024; out_ready = 1'b1; lock = 1'b1;
    step();
    lock = 1'b0;
    step();
    check("t35_relock", sel, 16'h0004);
    step();
    step();
    check("t35_g5", sel, 16'h0020);
    step();
`endif

    // Randomized traffic with sparse and dense request patterns.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: req = 16'h0001 << $urandom_range(0, 15);
        1: req = 16'($urandom) & 16'($urandom);
        2: req = 16'($urandom);
        default: req = 16'h0000;
      endcase
      for (int j = 0; j < 16; j++) chan_data[j*CHANSIZE +: CHANSIZE] = CHANSIZE'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      lock = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
